// File: rtl/regfile_wb_arbiter.sv
// Two-slot write-back arbiter in front of a dual-port register file.
// Same-address collisions are serialised through a one-entry skid so slot 1 lands last.
module regfile_wb_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req0_valid,
  input  logic [4:0]       req0_addr,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_addr,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  output logic             regWrite1,
  output logic             regWrite2,
  output logic [31:0]      writeData_1,
  output logic [31:0]      writeData_2,
  output logic [31:0]      decOut,
  output logic [31:0]      writeData_sel,
  output logic [31:0]      busy,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [0:0] {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_state_t;

  skid_state_t state;

  logic        p1_valid, p2_valid;
  logic [4:0]  p1_addr, p2_addr, s_addr;
  logic [31:0] p1_data, p2_data, s_data;
  logic        s_valid;

  logic acc0, acc1, same_addr;
  logic load_p1, load_p2, load_s;

  // The skid's valid bit is the FSM state itself, so the two can never disagree.
  assign s_valid = (state == SKID_FULL);

  assign req1_ready = !s_valid;
  assign req0_ready = !(s_valid && (req0_addr == s_addr));

  assign acc0      = req0_valid && req0_ready;
  assign acc1      = req1_valid && req1_ready;
  assign same_addr = (req0_addr == req1_addr);

  // Address-0 requests are accepted but dropped; a collision diverts slot 1 into the skid.
  always_comb begin
    load_p1 = acc0 && (req0_addr != '0);
    load_s  = '0;
    load_p2 = '0;
    if (!s_valid && acc1 && (req1_addr != '0)) begin
      if (acc0 && same_addr) load_s  = 1'b1;
      else                   load_p2 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SKID_EMPTY;
      p1_valid     <= 1'b0;
      p1_addr      <= '0;
      p1_data      <= '0;
      p2_valid     <= 1'b0;
      p2_addr      <= '0;
      p2_data      <= '0;
      s_addr       <= '0;
      s_data       <= '0;
      conflict_cnt <= '0;
    end else begin
      p1_valid <= 1'b0;
      p2_valid <= 1'b0;
      if (flush) begin
        state <= SKID_EMPTY;
      end else begin
        if (load_p1) begin
          p1_valid <= 1'b1;
          p1_addr  <= req0_addr;
          p1_data  <= req0_data;
        end
        case (state)
          SKID_EMPTY: begin
            if (load_s) begin
              state  <= SKID_FULL;
              s_addr <= req1_addr;
              s_data <= req1_data;
              if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
            end else if (load_p2) begin
              p2_valid <= 1'b1;
              p2_addr  <= req1_addr;
              p2_data  <= req1_data;
            end
          end
          SKID_FULL: begin
            state    <= SKID_EMPTY;
            p2_valid <= 1'b1;
            p2_addr  <= s_addr;
            p2_data  <= s_data;
          end
          default: state <= SKID_EMPTY;
        endcase
      end
    end
  end

  assign regWrite1   = p1_valid;
  assign regWrite2   = p2_valid;
  assign writeData_1 = p1_data;
  assign writeData_2 = p2_data;

  always_comb begin
    decOut        = '0;
    writeData_sel = '0;
    busy          = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      decOut[i]        = (p1_valid && (p1_addr == i[4:0])) ||
                         (p2_valid && (p2_addr == i[4:0]));
      writeData_sel[i] = p2_valid && (p2_addr == i[4:0]);
      busy[i]          = decOut[i] || (s_valid && (s_addr == i[4:0]));
    end
  end

endmodule
